// File: rtl/display_mux_pkg.sv
// Shared types and enable-polarity helpers for the two-digit display multiplexer.
package display_pkg;

    typedef enum logic [1:0] {BLANK0, SHOW0, BLANK1, SHOW1} mux_state_t;

    typedef logic [3:0] digit_t;

    function automatic logic en_on_lvl(input bit active_low);
        return active_low ? 1'b0 : 1'b1;
    endfunction

    function automatic logic en_off_lvl(input bit active_low);
        return active_low ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/display_mux_if.sv
// Digit load inputs and decoder/enable outputs of the display multiplexer.
interface display_mux_if;
    import display_pkg::*;

    digit_t s0;
    digit_t s1;
    logic   load;
    digit_t s_out;
    logic   en0;
    logic   en1;
    logic   frame_done;

    modport master (output s0, s1, load, input s_out, en0, en1, frame_done);
    modport slave  (input s0, s1, load, output s_out, en0, en1, frame_done);
endinterface

// File: rtl/display_mux_slot_timer.sv
// Per-slot cycle counter; flags where the current cycle sits inside a digit slot.
module slot_timer #(
    parameter int REFRESH_DIV  = 24000,
    parameter int BLANK_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    output logic slot_last_o,
    output logic in_blank_o,
    output logic blank_last_o,
    output logic pre_last_o
);
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] PRE   = CW'(REFRESH_DIV - 2);
    localparam logic [CW-1:0] BCNT  = CW'(BLANK_CYCLES);
    localparam logic [CW-1:0] BLAST = CW'(BLANK_CYCLES - 1);

    logic [CW-1:0] cnt_q;

    assign slot_last_o  = (cnt_q == LAST);
    assign pre_last_o   = (cnt_q == PRE);
    assign in_blank_o   = (cnt_q < BCNT);
    assign blank_last_o = (cnt_q == BLAST);

    always_ff @(posedge clk) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= slot_last_o ? '0 : cnt_q + CW'(1);
    end
endmodule

// File: rtl/display_mux.sv
// Two-digit time-multiplexed driver: blank/show slots per digit, frame-aligned
// commit of newly loaded digits, all outputs registered from next-state values.
module display_mux
    import display_pkg::*;
#(
    parameter int REFRESH_DIV   = 24000,
    parameter int BLANK_CYCLES  = 64,
    parameter int ACTIVE_LOW_EN = 1
) (
    input  logic          clk,
    input  logic          reset,
    display_mux_if.slave  bus
);
    localparam logic EN_ON  = en_on_lvl(ACTIVE_LOW_EN != 0);
    localparam logic EN_OFF = en_off_lvl(ACTIVE_LOW_EN != 0);

    if (REFRESH_DIV < 2) begin : g_bad_div
        $error("display_mux: REFRESH_DIV must be >= 2");
    end
    if (BLANK_CYCLES < 1 || BLANK_CYCLES > REFRESH_DIV - 1) begin : g_bad_blank
        $error("display_mux: BLANK_CYCLES must be in 1..REFRESH_DIV-1");
    end

    logic slot_last, in_blank, blank_last, pre_last;

    slot_timer #(
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk          (clk),
        .reset        (reset),
        .slot_last_o  (slot_last),
        .in_blank_o   (in_blank),
        .blank_last_o (blank_last),
        .pre_last_o   (pre_last)
    );

    mux_state_t state_q, state_d;
    digit_t     act0_q, act1_q, act0_d, act1_d;
    digit_t     pend0_q, pend1_q;
    logic       pend_vld_q;
    digit_t     s_out_q;
    logic       en0_q, en1_q, fd_q;
    logic       commit;

    assign commit = (state_q == SHOW1) && slot_last;

    always_comb begin
        state_d = state_q;
        case (state_q)
            BLANK0:  if (blank_last) state_d = SHOW0;
            SHOW0:   if (slot_last)  state_d = BLANK1;
            BLANK1:  if (blank_last) state_d = SHOW1;
            SHOW1:   if (slot_last)  state_d = BLANK0;
            default: state_d = BLANK0;
        endcase

        // A load on the commit edge goes straight to the active digits.
        act0_d = act0_q;
        act1_d = act1_q;
        if (commit) begin
            if (bus.load) begin
                act0_d = bus.s0;
                act1_d = bus.s1;
            end else if (pend_vld_q) begin
                act0_d = pend0_q;
                act1_d = pend1_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= BLANK0;
            act0_q     <= '0;
            act1_q     <= '0;
            pend0_q    <= '0;
            pend1_q    <= '0;
            pend_vld_q <= 1'b0;
            s_out_q    <= '0;
            en0_q      <= EN_OFF;
            en1_q      <= EN_OFF;
            fd_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            act0_q  <= act0_d;
            act1_q  <= act1_d;
            if (bus.load) begin
                pend0_q    <= bus.s0;
                pend1_q    <= bus.s1;
                pend_vld_q <= !commit;
            end else if (commit) begin
                pend_vld_q <= 1'b0;
            end
            // Next digit is presented during its blanking so the decoder settles first.
            s_out_q <= (state_d == BLANK0 || state_d == SHOW0) ? act0_d : act1_d;
            en0_q   <= (state_d == SHOW0) ? EN_ON : EN_OFF;
            en1_q   <= (state_d == SHOW1) ? EN_ON : EN_OFF;
            fd_q    <= (state_d == SHOW1) && pre_last;
        end
    end

    assign bus.s_out      = s_out_q;
    assign bus.en0        = en0_q;
    assign bus.en1        = en1_q;
    assign bus.frame_done = fd_q;

    a_en_excl: assert property (@(posedge clk) disable iff (!reset)
        !(en0_q == EN_ON && en1_q == EN_ON));
    a_blank_sync: assert property (@(posedge clk) disable iff (!reset)
        ((state_q == BLANK0 || state_q == BLANK1) == in_blank));
endmodule
